// File: rtl/byte_minmax_tracker_pkg.sv
// Shared types and constants for the byte min/max tracker.
// Holds the FSM state enum, data width and register reset values.
package byte_minmax_tracker_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] MAX_RST = 8'h00;
    localparam logic [DATA_W-1:0] MIN_RST = 8'hFF;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/eight_bit_comparator.sv
// Unsigned 8-bit magnitude comparator.
// G: A > B, E: A == B, L: A < B.
module eight_bit_comparator (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       G,
    output logic       E,
    output logic       L
);

    assign G = (A > B);
    assign E = (A == B);
    assign L = (A < B);

endmodule

// File: rtl/byte_minmax_tracker.sv
// Per-frame max/min tracker over WINDOW unsigned byte samples.
// Define MINMAX_RANGE_EN to add the registered range_out = max - min.
module byte_minmax_tracker
    import byte_minmax_tracker_pkg::*;
#(
    parameter int WINDOW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
`ifdef MINMAX_RANGE_EN
    output logic [DATA_W-1:0] range_out,
`endif
    output logic [DATA_W-1:0] count_out
);

    localparam logic [DATA_W-1:0] LAST = DATA_W'(WINDOW - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] min_q, min_d;

    logic accept;
    logic first;
    logic last;

    logic max_g;
    logic max_e_unused;
    logic max_l_unused;
    logic min_l;
    logic min_e_unused;
    logic min_g_unused;

    eight_bit_comparator u_cmp_max (
        .A (in_data),
        .B (max_q),
        .G (max_g),
        .E (max_e_unused),
        .L (max_l_unused)
    );

    eight_bit_comparator u_cmp_min (
        .A (in_data),
        .B (min_q),
        .G (min_g_unused),
        .E (min_e_unused),
        .L (min_l)
    );

    assign in_ready  = (state_q == ACCUM) && !clear;
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign first     = (count_q == '0);
    assign last      = (count_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept && last) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
            endcase
        end
    end

    // Max/min survive clear and consume; only the next first sample reloads them.
    always_comb begin
        count_d = count_q;
        max_d   = max_q;
        min_d   = min_q;
        if (clear) begin
            count_d = '0;
        end else if (out_valid && out_ready) begin
            count_d = '0;
        end else if (accept) begin
            count_d = count_q + 8'd1;
            if (first) begin
                max_d = in_data;
                min_d = in_data;
            end else begin
                if (max_g) begin
                    max_d = in_data;
                end
                if (min_l) begin
                    min_d = in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            max_q   <= MAX_RST;
            min_q   <= MIN_RST;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
            min_q   <= min_d;
        end
    end

`ifdef MINMAX_RANGE_EN
    logic [DATA_W-1:0] range_q, range_d;

    always_comb begin
        range_d = range_q;
        if (!clear && accept) begin
            range_d = max_d - min_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_q <= '0;
        end else begin
            range_q <= range_d;
        end
    end

    assign range_out = range_q;
`endif

    assign max_out   = max_q;
    assign min_out   = min_q;
    assign count_out = count_q;

endmodule

// File: doc/byte_minmax_tracker.md
BYTE_MINMAX_TRACKER -- requirements
Module: byte_minmax_tracker

Interface
REQ-001 The block SHALL have parameter WINDOW, default 8, meaning the number of samples per frame (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clear, input, 1, a synchronous abort of the current frame.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream sample is valid.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept a sample this cycle.
REQ-007 The block SHALL have port in_data, input, 8, an unsigned sample.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the frame result is valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 The block SHALL have ports max_out and min_out, output, 8 each, holding the frame maximum and minimum.
REQ-011 The block SHALL have port count_out, output, 8, holding the number of samples accepted in the current frame.

Function
REQ-012 The block SHALL use the FSM states ACCUM and HOLD.
REQ-013 in_ready SHALL equal (state==ACCUM) && !clear.
REQ-014 A sample is accepted on a cycle where in_valid && in_ready.
REQ-015 The first accepted sample of a frame SHALL load both max_out and min_out, with no comparison.
REQ-016 For a later accepted sample, max_out SHALL update only if comparator G(in_data vs max) = 1, and min_out SHALL update only if comparator L(in_data vs min) = 1.
REQ-017 For a later accepted sample with E = 1, neither max_out nor min_out SHALL change.
REQ-018 count_out SHALL increment by 1 per accepted sample, with 1-cycle latency (registered).
REQ-019 On the cycle the WINDOW-th sample is accepted, the FSM SHALL go ACCUM->HOLD, with out_valid=1 from the next cycle.
REQ-020 In HOLD, max_out, min_out and count_out SHALL be stable and in_ready SHALL be 0.
REQ-021 A result is consumed on a cycle where out_valid && out_ready; the block SHALL then go HOLD->ACCUM, set count_out=0 and out_valid=0 next cycle.
REQ-022 max_out and min_out SHALL retain their last values until the first sample of the next frame.
REQ-023 clear (any state) SHALL force the next state to ACCUM with count_out=0 and out_valid=0.
REQ-024 clear SHALL win over a simultaneous in_valid (sample not accepted) and over a simultaneous out_ready (result dropped, not consumed).
REQ-025 All arithmetic SHALL be unsigned 8-bit.
REQ-026 count_out SHALL never exceed WINDOW.

Reset
REQ-027 While rst=1, the block SHALL hold state=ACCUM, max_out=0x00, min_out=0xFF, count_out=0 and out_valid=0.
REQ-028 in_ready SHALL be 1 once rst deasserts, given clear=0.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending result immediately, without waiting for a clock edge.

Configuration
REQ-030 With MINMAX_RANGE_EN defined, the block SHALL add output range_out[7:0] = max_out - min_out, registered together with max_out and min_out, reset value 0x00, and valid whenever out_valid=1.
REQ-031 Without MINMAX_RANGE_EN, range_out and its subtractor SHALL be absent, with all other behaviour identical.

Structure
REQ-032 A shared package SHALL hold the state enum (ACCUM, HOLD), the constants DATA_W=8 and the reset values MAX_RST=0x00 and MIN_RST=0xFF.
REQ-033 The block SHALL instantiate the existing eight_bit_comparator sub-module twice, both with A=in_data: once with B=max_out, using G, and once with B=min_out, using L.
REQ-034 The block SHALL use no other sub-modules.

Verification
REQ-035 With WINDOW=8, samples 0xC3,0xCB,0x43,0x4B,0xCA,0x40,0xFF,0x02 and out_ready=1 SHALL give out_valid for exactly 1 cycle with max=0xFF, min=0x02, count=8 (range=0xFD if MINMAX_RANGE_EN).
REQ-036 With WINDOW=8, eight samples all 0x4B SHALL give max=min=0x4B (range=0x00).
REQ-037 Holding out_ready=0 for 5 cycles after frame end SHALL keep out_valid=1 and in_ready=0 with stable outputs, and the 6th cycle with out_ready=1 SHALL return the block to ACCUM.
REQ-038 Asserting clear after 3 of 8 samples, together with in_valid, SHALL drop that sample and set count_out=0 next cycle; the following 8 samples SHALL form a clean frame.
REQ-039 Pulsing rst asynchronously in HOLD SHALL immediately give out_valid=0, max=0x00, min=0xFF, count=0.
REQ-040 Back-to-back frames with in_valid held at 1 SHALL produce exactly one in_ready=0 HOLD cycle between frames when out_ready=1.
